cavlc_coeff_stats: RTL

Upstream statistics stage for CAVLC coeff_token encoding. Accepts one 4x4 block's quantised coefficients, already in zigzag order, at one coefficient per cycle. When the block completes, it outputs TotalCoeff, TrailingOnes, TotalZeros and the trailing-one signs. It also outputs the coeff_token lookup address {TrailingOnes, TotalCoeff}, which drives the coeff_token VLC table stages directly.

---
 rtl/cavlc_coeff_stats.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cavlc_coeff_stats.sv
// CAVLC coeff_token statistics: TotalCoeff, TrailingOnes, TotalZeros and
// trailing-one signs gathered from one zigzag-ordered 4x4 block.
module cavlc_coeff_stats #(
  parameter int CWIDTH    = 16,
  parameter int MAX_COEFF = 16,
  parameter int aWIDTH    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CWIDTH-1:0] coeff_in,
  input  logic              coeff_valid,
  input  logic              coeff_last,
  output logic              coeff_ready,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [4:0]        total_coeff,
  output logic [1:0]        trailing_ones,
  output logic [3:0]        total_zeros,
  output logic [2:0]        t1_signs,
  output logic [aWIDTH-1:0] vlc_addr,
  output logic              stat_err
);

  typedef enum logic {
    ACCUM,
    DONE
  } state_t;

  state_t st, st_n;

  logic [4:0] idx;
  logic [4:0] tc;
  logic [3:0] tz;
  logic [3:0] zrun;
  logic [1:0] t1run;
  logic [2:0] sgn;
  logic       err;
  logic [2:0] mask;

  logic acc, term, hs;
  logic is_nz, is_one;

  assign acc  = (st == ACCUM) && coeff_valid;
  assign term = acc && (coeff_last || (idx == 5'(MAX_COEFF - 1)));
  assign hs   = (st == DONE) && stat_ready;

  // exact compare: the most-negative code is not a one
  assign is_nz  = coeff_in != '0;
  assign is_one = (coeff_in == CWIDTH'(1))
               || (coeff_in == {CWIDTH{1'b1}});

  always_comb begin
    st_n        = st;
    coeff_ready = 1'b0;
    stat_valid  = 1'b0;
    unique case (st)
      ACCUM: begin
        coeff_ready = 1'b1;
        if (term) st_n = DONE;
      end
      DONE: begin
        stat_valid = 1'b1;
        if (stat_ready) st_n = ACCUM;
      end
      default: st_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st <= ACCUM;
    else     st <= st_n;
  end

  always_ff @(posedge clk) begin
    if (rst || hs) begin
      idx   <= '0;
      tc    <= '0;
      tz    <= '0;
      zrun  <= '0;
      t1run <= '0;
      sgn   <= '0;
      err   <= 1'b0;
    end else if (acc) begin
      idx <= idx + 5'd1;
      if (is_nz) begin
        tc   <= tc + 5'd1;
        tz   <= tz + zrun;
        zrun <= '0;
        if (is_one) begin
          t1run <= (t1run == 2'd3) ? 2'd3 : t1run + 2'd1;
          sgn   <= {sgn[1:0], coeff_in[CWIDTH-1]};
        end else begin
          t1run <= '0;
          sgn   <= '0;
        end
      end else begin
        zrun <= zrun + 4'd1;
      end
      if (term) begin
        idx <= '0;
        err <= ~coeff_last;
      end
    end
  end

  always_comb begin
    mask = 3'b000;
    unique case (t1run)
      2'd0: mask = 3'b000;
      2'd1: mask = 3'b001;
      2'd2: mask = 3'b011;
      2'd3: mask = 3'b111;
      default: mask = 3'b000;
    endcase
  end

  assign total_coeff   = tc;
  assign trailing_ones = t1run;
  assign total_zeros   = tz;
  assign t1_signs      = sgn & mask;
  assign vlc_addr      = aWIDTH'({t1run, tc});
  assign stat_err      = err;

endmodule
